// File: rtl/cic_pkg.sv
// cic_pkg: shared sizing and saturation helpers for the CIC filter family.
package cic_pkg;

  // Ceiling log2 with a constant loop bound so it elaborates and synthesises cleanly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Internal datapath width: input width plus worst-case CIC bit growth.
  function automatic int unsigned cic_width(input int unsigned din_w, input int unsigned n,
                                            input int unsigned r, input int unsigned m);
    return din_w + n * clog2(r * m);
  endfunction

  // Right shift that brings the interpolator DC gain back to unity.
  function automatic int unsigned cic_gain_shift(input int unsigned n, input int unsigned r,
                                                 input int unsigned m);
    return n * clog2(r * m) - clog2(r);
  endfunction

  // Clamp a signed value into the signed range of a w-bit word (1 <= w <= 63).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one comb section y = x - x[n-M], advancing only when enabled.
module cic_comb_stage #(
  parameter int unsigned W = 22,
  parameter int unsigned M = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                i_en,
  input  logic signed [W-1:0] i_x,
  output logic signed [W-1:0] o_y
);

  logic signed [W-1:0] r_dly [M];

  assign o_y = i_x - r_dly[M-1];

  // Differential delay line, shifted once per accepted input sample.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < M; i++) r_dly[i] <= '0;
    end else if (i_en) begin
      r_dly[0] <= i_x;
      for (int unsigned i = 1; i < M; i++) r_dly[i] <= r_dly[i-1];
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: streaming CIC interpolator, R high-rate outputs per low-rate input.
// Comb chain runs at the input rate, integrators at the output rate with zero stuffing.
// Build option: define CIC_INTERP_ROUND_EN for round-half-up plus output saturation;
// otherwise the output is truncated and wraps.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int unsigned DIN_W = 16,
  parameter int unsigned N     = 3,
  parameter int unsigned R     = 4,
  parameter int unsigned M     = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [DIN_W-1:0] s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,
  output logic [DIN_W-1:0] m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready
);

  localparam int unsigned W          = cic_width(DIN_W, N, R, M);
  localparam int unsigned GAIN_SHIFT = cic_gain_shift(N, R, M);
  localparam int unsigned PW         = clog2(R);

  logic signed [W-1:0] w_comb [N+1];
  logic signed [W-1:0] w_x;
  logic [DIN_W-1:0]    w_out;
  logic                w_accept;
  logic                w_adv;

  logic signed [W-1:0] r_comb;
  logic                r_pend;
  logic [PW-1:0]       r_phase;
  logic signed [W-1:0] r_integ [N];
  logic [DIN_W-1:0]    r_tdata;
  logic                r_tvalid;

  assign s_axis_data_tready = !r_pend;
  assign m_axis_data_tdata  = r_tdata;
  assign m_axis_data_tvalid = r_tvalid;

  assign w_accept = s_axis_data_tvalid && !r_pend;
  assign w_adv    = (!r_tvalid || m_axis_data_tready) && ((r_phase != '0) || r_pend);
  assign w_x      = (r_phase == '0) ? r_comb : '0;

  assign w_comb[0] = {{(W-DIN_W){s_axis_data_tdata[DIN_W-1]}}, s_axis_data_tdata};

  for (genvar g = 0; g < N; g++) begin : g_comb
    cic_comb_stage #(
      .W (W),
      .M (M)
    ) u_comb (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_en    (w_accept),
      .i_x     (w_comb[g]),
      .o_y     (w_comb[g+1])
    );
  end

`ifdef CIC_INTERP_ROUND_EN
  localparam int unsigned      RND_SH = (GAIN_SHIFT > 0) ? GAIN_SHIFT - 1 : 0;
  localparam logic signed [W:0] RND   = (GAIN_SHIFT > 0) ? ((W+1)'(1) <<< RND_SH) : '0;

  logic signed [W:0] w_rnd;

  // One guard bit keeps the rounding offset from wrapping before the clamp.
  assign w_rnd = $signed({r_integ[N-1][W-1], r_integ[N-1]}) + RND;
  assign w_out = DIN_W'(saturate(64'($signed(w_rnd >>> GAIN_SHIFT)), DIN_W));
`else
  assign w_out = DIN_W'(r_integ[N-1] >>> GAIN_SHIFT);
`endif

  // Input side: hold the comb result until the integrators consume it at phase 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_comb <= '0;
      r_pend <= 1'b0;
    end else begin
      if (w_adv && (r_phase == '0)) r_pend <= 1'b0;
      if (w_accept) begin
        r_comb <= w_comb[N];
        r_pend <= 1'b1;
      end
    end
  end

  // Pipelined integrators and phase counter, stepping once per output slot.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned k = 0; k < N; k++) r_integ[k] <= '0;
      r_phase <= '0;
    end else if (w_adv) begin
      r_integ[0] <= r_integ[0] + w_x;
      for (int unsigned k = 1; k < N; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
      r_phase <= r_phase + PW'(1);
    end
  end

  // Output register: load on each step, otherwise drop valid once the sink takes it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else if (w_adv) begin
      r_tdata  <= w_out;
      r_tvalid <= 1'b1;
    end else if (m_axis_data_tready) begin
      r_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
`timescale 1ns/1ps
module tb_cic_interpolator;

  localparam int DIN_W  = 16;
  localparam int N      = 3;
  localparam int R      = 4;
  localparam int M      = 1;
  localparam int GS     = N * $clog2(R * M) - $clog2(R);
  localparam int HLEN   = N * (R * M - 1) + 1;
  localparam int BUDGET = 4000;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [DIN_W-1:0] s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [DIN_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b1;

  always #5 aclk = ~aclk;

  cic_interpolator #(
    .DIN_W (DIN_W),
    .N     (N),
    .R     (R),
    .M     (M)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     in_q[$];
  int     out_q[$];
  int     exp_q[$];
  int     base_q[$];
  longint h[HLEN];
  int     hold_viol, starve_cyc, sready_low, extra_out, acc_cyc, nz_cyc;

  // Impulse response of the ideal filter: N-fold convolution of a length R*M boxcar.
  task automatic build_h();
    longint tmp[HLEN];
    for (int i = 0; i < HLEN; i++) h[i] = (i == 0) ? 1 : 0;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < HLEN; i++) begin
        tmp[i] = 0;
        for (int d = 0; d < R * M; d++) if (i - d >= 0) tmp[i] += h[i-d];
      end
      for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
    end
  endtask

  function automatic int scale(input longint y);
    longint v;
`ifdef CIC_INTERP_ROUND_EN
    v = (y + (longint'(1) <<< (GS - 1))) >>> GS;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
`else
    v = y >>> GS;
    return int'(shortint'(v));
`endif
  endfunction

  // Expected stream: zero-stuffed input convolved with h, delayed by N pipeline slots.
  task automatic build_expected();
    exp_q.delete();
    for (int j = 0; j < in_q.size() * R; j++) begin
      longint y = 0;
      int n = j - N;
      for (int k = 0; k < HLEN; k++) begin
        int m = n - k;
        if (m >= 0 && (m % R) == 0 && (m / R) < in_q.size()) y += h[k] * longint'(in_q[m / R]);
      end
      exp_q.push_back(scale(y));
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Drives in_q (one offer every 'gap' cycles, held until accepted), random sink stalls,
  // and collects every output handshake into out_q.
  task automatic run_stream(input int gap, input int bp_pct);
    int idx = 0, cyc = 0, target;
    bit holding = 0, prev_stall = 0, started = 0;
    logic [DIN_W-1:0] prev_data = '0;
    target = in_q.size() * R;
    out_q.delete();
    hold_viol = 0; starve_cyc = 0; sready_low = 0; extra_out = 0; acc_cyc = -1; nz_cyc = -1;
    while (out_q.size() < target && cyc < BUDGET) begin
      @(negedge aclk);
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data)) hold_viol++;
      if (started && !m_tvalid && idx < in_q.size()) starve_cyc++;
      if (!s_tready) sready_low++;
      if (m_tvalid && m_tdata != '0 && nz_cyc < 0) nz_cyc = cyc;
      if (!holding && idx < in_q.size() && (cyc % gap) == 0) holding = 1;
      s_tvalid = holding;
      s_tdata  = holding ? DIN_W'(in_q[idx]) : '0;
      m_tready = ($urandom_range(99) >= bp_pct);
      #1;
      if (s_tvalid && s_tready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        idx++;
        holding = 0;
      end
      if (m_tvalid && m_tready) out_q.push_back(int'($signed(m_tdata)));
      if (m_tvalid) started = 1;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      cyc++;
    end
    s_tvalid = 1'b0;
    repeat (12) begin
      @(negedge aclk);
      m_tready = 1'b1;
      #1;
      if (m_tvalid) extra_out++;
    end
  endtask

  task automatic test_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
    n_cmp++; if (m_tdata !== '0) begin n_err++; $display("FAIL reset_tdata got=%0d want=0", m_tdata); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready got=%b want=1", s_tready); end
    do_reset();
  endtask

  task automatic test_impulse(input string tag);
    int ref_imp[24];
    int tbl[10] = '{1024, 3072, 6144, 10240, 12288, 12288, 10240, 6144, 3072, 1024};
    for (int i = 0; i < 24; i++) ref_imp[i] = (i >= N && i < N + 10) ? tbl[i - N] : 0;
    in_q = '{16384, 0, 0, 0, 0, 0};
    run_stream(1, 0);
    n_cmp++;
    if (out_q.size() != 24) begin
      n_err++; $display("FAIL %s_count got=%0d want=24", tag, out_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        n_cmp++;
        if (out_q[i] != ref_imp[i]) begin
          n_err++; $display("FAIL %s_out[%0d] got=%0d want=%0d", tag, i, out_q[i], ref_imp[i]);
        end
      end
    end
    n_cmp++;
    if (nz_cyc - acc_cyc != N + 2) begin
      n_err++; $display("FAIL %s_latency got=%0d want=%0d", tag, nz_cyc - acc_cyc, N + 2);
    end
  endtask

  task automatic test_constant();
    do_reset();
    in_q.delete();
    repeat (20) in_q.push_back(1000);
    build_expected();
    run_stream(1, 0);
    n_cmp++;
    if (out_q.size() != 80 || extra_out != 0) begin
      n_err++; $display("FAIL const_count got=%0d+%0d want=80+0", out_q.size(), extra_out);
    end else begin
      for (int j = 0; j < 80; j++) begin
        n_cmp++;
        if (out_q[j] != exp_q[j] || (j >= N + HLEN - 1 && out_q[j] != 1000)) begin
          n_err++; $display("FAIL const_out[%0d] got=%0d want=%0d", j, out_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_throttled();
    in_q.delete();
    repeat (12) in_q.push_back(int'($urandom_range(65535)) - 32768);
    build_expected();
    do_reset();
    run_stream(1, 0);
    base_q = out_q;
    do_reset();
    run_stream(7, 0);
    n_cmp++;
    if (out_q.size() != exp_q.size() || base_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL throttle_count got=%0d/%0d want=%0d", out_q.size(), base_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_cmp++;
        if (out_q[j] != exp_q[j] || base_q[j] != exp_q[j]) begin
          n_err++; $display("FAIL throttle_out[%0d] got=%0d/%0d want=%0d", j, out_q[j], base_q[j], exp_q[j]);
        end
      end
    end
    n_cmp++;
    if (starve_cyc == 0) begin n_err++; $display("FAIL throttle_gaps got=0 want>0"); end
  endtask

  task automatic test_backpressure();
    in_q.delete();
    repeat (16) in_q.push_back(int'($urandom_range(65535)) - 32768);
    build_expected();
    do_reset();
    run_stream(1, 50);
    n_cmp++;
    if (out_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL bp_count got=%0d want=%0d", out_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_cmp++;
        if (out_q[j] != exp_q[j]) begin
          n_err++; $display("FAIL bp_out[%0d] got=%0d want=%0d", j, out_q[j], exp_q[j]);
        end
      end
    end
    n_cmp++;
    if (hold_viol != 0) begin n_err++; $display("FAIL bp_hold got=%0d want=0", hold_viol); end
    n_cmp++;
    if (sready_low == 0) begin n_err++; $display("FAIL bp_sready_drop got=0 want>0"); end
  endtask

  task automatic test_full_scale();
    in_q.delete();
    repeat (20) in_q.push_back(-32768);
    build_expected();
    do_reset();
    run_stream(1, 0);
    n_cmp++;
    if (out_q.size() != 80) begin
      n_err++; $display("FAIL fs_count got=%0d want=80", out_q.size());
    end else begin
      for (int j = 0; j < 80; j++) begin
        n_cmp++;
        if (out_q[j] != exp_q[j] || (j >= N + HLEN - 1 && out_q[j] != -32768)) begin
          n_err++; $display("FAIL fs_out[%0d] got=%0d want=%0d", j, out_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int hs = 0, cyc = 0;
    do_reset();
    while (hs < 5 && cyc < 100) begin
      @(negedge aclk);
      s_tvalid = 1'b1;
      s_tdata  = DIN_W'($urandom_range(65535));
      m_tready = 1'b1;
      #1;
      if (m_tvalid && m_tready) hs++;
      cyc++;
    end
    n_cmp++;
    if (hs < 5) begin n_err++; $display("FAIL mid_progress got=%0d want=5", hs); end
    @(negedge aclk);
    #2;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_tvalid got=%b want=0", m_tvalid); end
    n_cmp++; if (m_tdata !== '0) begin n_err++; $display("FAIL mid_tdata got=%0d want=0", m_tdata); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL mid_tready got=%b want=1", s_tready); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    test_impulse("mid_impulse");
  endtask

  initial begin
    build_h();
    test_reset();
    test_impulse("impulse");
    test_constant();
    test_throttled();
    test_backpressure();
    test_full_scale();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
